// File: rtl/gpio_ser_tx.sv
// Front-panel GPIO serial transmitter: shifts a parallel word MSB-first onto SCLK/SDAT/SFRM pins,
// with the remaining GPIO bits passed through from gpio_out under OUT_MASK.
//
// state      | meaning
// S_IDLE     | ready for a word, serial pins low
// S_SETUP    | SFRM high, first bit presented, SCLK low
// S_SHIFT_HI | SCLK high, SDAT stable
// S_SHIFT_LO | SCLK low, next bit presented
// S_HOLD     | SCLK low, SFRM and last bit held before frame end
module gpio_ser_tx #(
    parameter int GPIO_REG_WIDTH = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int CLK_DIV_FAC    = 10,
    parameter int SCLK_BIT       = 0,
    parameter int SDAT_BIT       = 2,
    parameter int SFRM_BIT       = 4,
    parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK = 12'hD55,
    parameter logic [GPIO_REG_WIDTH-1:0] IO_DDR   = 12'hD55
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    output logic                      busy
);

    localparam int HP_W = $clog2(CLK_DIV_FAC + 1);
    localparam int BC_W = $clog2(DATA_WIDTH + 1);
    localparam logic [HP_W-1:0] HP_LOAD = HP_W'(CLK_DIV_FAC - 1);
    localparam logic [BC_W-1:0] BC_LOAD = BC_W'(DATA_WIDTH);
    localparam logic [GPIO_REG_WIDTH-1:0] SER_MASK =
        (GPIO_REG_WIDTH'(1) << SCLK_BIT) |
        (GPIO_REG_WIDTH'(1) << SDAT_BIT) |
        (GPIO_REG_WIDTH'(1) << SFRM_BIT);

    if (SCLK_BIT == SDAT_BIT || SCLK_BIT == SFRM_BIT || SDAT_BIT == SFRM_BIT) begin : g_idx_dup
        $error("gpio_ser_tx: serial pin indices must be distinct");
    end
    if (SCLK_BIT >= GPIO_REG_WIDTH || SDAT_BIT >= GPIO_REG_WIDTH ||
        SFRM_BIT >= GPIO_REG_WIDTH || SCLK_BIT < 0 || SDAT_BIT < 0 || SFRM_BIT < 0) begin : g_idx_range
        $error("gpio_ser_tx: serial pin index outside the GPIO bank");
    end
    if (DATA_WIDTH < 1 || CLK_DIV_FAC < 1) begin : g_param_range
        $error("gpio_ser_tx: DATA_WIDTH and CLK_DIV_FAC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_HOLD
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [HP_W-1:0]           r_hp_cnt;
    logic [BC_W-1:0]           r_bit_cnt;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_ready;
    logic                      r_busy;
    logic [GPIO_REG_WIDTH-1:0] r_pins;
    logic [GPIO_REG_WIDTH-1:0] r_ddr;

    logic                      w_hp_tc;
    logic                      w_last_bit;
    logic                      w_hp_load;
    logic                      w_capture;
    logic                      w_shift;
    logic                      w_bit_dec;
    logic                      w_sclk;
    logic                      w_sdat;
    logic                      w_sfrm;
    logic [GPIO_REG_WIDTH-1:0] w_pins;

    assign w_hp_tc    = (r_hp_cnt == '0);
    assign w_last_bit = (r_bit_cnt == BC_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hp_load   = 1'b0;
        w_capture   = 1'b0;
        w_shift     = 1'b0;
        w_bit_dec   = 1'b0;
        w_sclk      = 1'b0;
        w_sdat      = 1'b0;
        w_sfrm      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_tvalid && r_ready) begin
                    w_capture   = 1'b1;
                    w_hp_load   = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_sfrm = 1'b1;
                w_sdat = r_shift[DATA_WIDTH-1];
                if (w_hp_tc) begin
                    w_hp_load   = 1'b1;
                    w_state_nxt = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                w_sfrm = 1'b1;
                w_sclk = 1'b1;
                w_sdat = r_shift[DATA_WIDTH-1];
                if (w_hp_tc) begin
                    w_hp_load = 1'b1;
                    w_bit_dec = 1'b1;
                    if (w_last_bit) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        // advance the data as SCLK falls so SDAT only moves while SCLK is low
                        w_shift     = 1'b1;
                        w_state_nxt = S_SHIFT_LO;
                    end
                end
            end
            S_SHIFT_LO: begin
                w_sfrm = 1'b1;
                w_sdat = r_shift[DATA_WIDTH-1];
                if (w_hp_tc) begin
                    w_hp_load   = 1'b1;
                    w_state_nxt = S_SHIFT_HI;
                end
            end
            S_HOLD: begin
                w_sfrm = 1'b1;
                w_sdat = r_shift[DATA_WIDTH-1];
                if (w_hp_tc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hp_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_hp_load) begin
                r_hp_cnt <= HP_LOAD;
            end else if (!w_hp_tc) begin
                r_hp_cnt <= r_hp_cnt - HP_W'(1);
            end
            if (w_capture) begin
                r_bit_cnt <= BC_LOAD;
            end else if (w_bit_dec) begin
                r_bit_cnt <= r_bit_cnt - BC_W'(1);
            end
            if (w_capture) begin
                r_shift <= s_tdata;
            end else if (w_shift) begin
                r_shift <= r_shift << 1;
            end
        end
    end

    always_comb begin
        w_pins           = gpio_out & OUT_MASK & ~SER_MASK;
        w_pins[SCLK_BIT] = w_sclk;
        w_pins[SDAT_BIT] = w_sdat;
        w_pins[SFRM_BIT] = w_sfrm;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pins  <= '0;
            r_ddr   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_pins  <= w_pins;
            r_ddr   <= IO_DDR | SER_MASK;
            r_busy  <= w_sfrm;
            r_ready <= (w_state_nxt == S_IDLE);
        end
    end

    assign fp_gpio_out = r_pins;
    assign fp_gpio_ddr = r_ddr;
    assign busy        = r_busy;
    assign s_tready    = r_ready;

endmodule

// File: tb/tb_gpio_ser_tx.sv
// Bench for gpio_ser_tx: a pin-level monitor decodes each frame (length, SCLK rises, sampled bits)
// and compares it with the words handed over on the valid/ready handshake.
module tb_gpio_ser_tx;

    localparam logic [11:0] SER   = 12'h015;
    localparam logic [11:0] PASS  = 12'hD40;
    localparam int          N     = 10;
    localparam int          DW    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [11:0] gpio_out;
    logic [11:0] fp_gpio_out;
    logic [11:0] fp_gpio_ddr;
    logic        busy;

    logic        b_tdata;
    logic        b_tvalid;
    logic        b_tready;
    logic [11:0] b_fp;
    logic [11:0] b_ddr;
    logic        b_busy;

    always #5 clk = ~clk;

    gpio_ser_tx dut (
        .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .gpio_out(gpio_out), .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr), .busy(busy)
    );

    gpio_ser_tx #(.DATA_WIDTH(1), .CLK_DIV_FAC(1)) dut_min (
        .clk(clk), .reset(reset), .s_tdata(b_tdata), .s_tvalid(b_tvalid), .s_tready(b_tready),
        .gpio_out(gpio_out), .fp_gpio_out(b_fp), .fp_gpio_ddr(b_ddr), .busy(b_busy)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s obs=%0h want=%0h", tag, obs, want);
        end
    endtask

    logic [15:0] exp_q[$];
    logic [11:0] gpio_q;
    logic        rst_q;

    always @(posedge clk) begin
        gpio_q <= gpio_out;
        rst_q  <= reset;
    end

    // frame monitor
    bit          m_in;
    bit          m_prev_sclk;
    bit          m_prev_sdat;
    int          m_gap;
    int          m_last_gap;
    int          m_len;
    int          m_rises;
    int          m_cyc;
    int          m_last_rise;
    logic [15:0] m_word;

    always @(negedge clk) begin
        logic sclk, sdat, sfrm;
        if (!reset) begin
            chk_val("rst_pins", fp_gpio_out, 0);
            m_in        = 1'b0;
            m_prev_sclk = 1'b0;
            m_prev_sdat = 1'b0;
            m_gap       = 0;
        end else begin
            sclk = fp_gpio_out[0];
            sdat = fp_gpio_out[2];
            sfrm = fp_gpio_out[4];
            chk_val("busy_vs_frame", busy, sfrm);
            chk_val("passthru", fp_gpio_out & ~SER, rst_q ? (gpio_q & PASS) : 12'h000);
            if (!sfrm) chk_val("idle_serial", {sclk, sdat}, 0);
            if (sfrm) begin
                if (!m_in) begin
                    m_in        = 1'b1;
                    m_last_gap  = m_gap;
                    m_len       = 0;
                    m_rises     = 0;
                    m_cyc       = 0;
                    m_last_rise = 0;
                    m_word      = '0;
                end
                m_len++;
                if (sclk && !m_prev_sclk) begin
                    m_rises++;
                    m_word = {m_word[14:0], sdat};
                    if (m_rises > 1) chk_val("sclk_period", m_cyc - m_last_rise, 2 * N);
                    m_last_rise = m_cyc;
                end
                if (sclk && m_prev_sclk) chk_val("sdat_stable", sdat, m_prev_sdat);
                m_cyc++;
            end else if (m_in) begin
                m_in = 1'b0;
                chk_val("frame_len", m_len, N * (2 * DW + 1));
                chk_val("sclk_rises", m_rises, DW);
                if (exp_q.size() > 0) begin
                    chk_val("frame_data", m_word, exp_q.pop_front());
                end else begin
                    chk_val("frame_unexpected", exp_q.size(), 1);
                end
                m_gap = 1;
            end else begin
                m_gap++;
            end
            m_prev_sclk = sclk;
            m_prev_sdat = sdat;
        end
    end

    task automatic send_word(input logic [15:0] w, input bit keep_valid);
        int t;
        @(posedge clk);
        #1;
        s_tdata  = w;
        s_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_tready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk_val("tready_wait", s_tready, 1);
        if (s_tready) begin
            @(posedge clk);
            exp_q.push_back(w);
            #1;
            if (!keep_valid) s_tvalid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_in) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk_val("drain", exp_q.size() + int'(m_in), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, rises, sdat_at_rise;
        bit prev;
        reset    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        gpio_out = '0;
        b_tvalid = 1'b0;
        b_tdata  = 1'b0;

        repeat (3) @(negedge clk);
        chk_val("rst_fp", fp_gpio_out, 0);
        chk_val("rst_ddr", fp_gpio_ddr, 0);
        chk_val("rst_tready", s_tready, 0);
        chk_val("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_val("tready_before_edge", s_tready, 0);
        @(negedge clk);
        chk_val("tready_after_rel", s_tready, 1);
        chk_val("ddr_after_rel", fp_gpio_ddr, 12'hD55);
        chk_val("fp_after_rel", fp_gpio_out, 0);

        send_word(16'hA5C3, 1'b0);
        wait_idle();

        send_word(16'hFFFF, 1'b1);
        send_word(16'h0001, 1'b0);
        wait_idle();
        chk_val("b2b_gap", m_last_gap, 1);

        gpio_out = 12'hFFF;
        send_word(16'($urandom), 1'b0);
        repeat (50) @(negedge clk);
        chk_val("gpio_fff_mask", fp_gpio_out & ~SER, 12'hD40);
        chk_val("gpio_fff_sfrm", fp_gpio_out[4], 1);
        wait_idle();
        gpio_out = 12'h000;

        send_word(16'h3C5A, 1'b0);
        repeat (100) @(posedge clk);
        chk_val("busy_before_rst", busy, 1);
        #3 reset = 1'b0;
        exp_q.delete();
        #1;
        chk_val("async_rst_fp", fp_gpio_out, 0);
        chk_val("async_rst_busy", busy, 0);
        chk_val("async_rst_ddr", fp_gpio_ddr, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_val("tready_after_rst2", s_tready, 1);
        send_word(16'h8001, 1'b0);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send_word(16'($urandom), 1'b0);
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(20, 70)) @(posedge clk);
                #1 gpio_out = 12'($urandom);
            end
            wait_idle();
        end
        gpio_out = 12'h000;

        @(posedge clk);
        #1;
        b_tdata  = 1'b1;
        b_tvalid = 1'b1;
        @(negedge clk);
        chk_val("min_tready", b_tready, 1);
        @(posedge clk);
        #1 b_tvalid = 1'b0;
        len = 0;
        rises = 0;
        sdat_at_rise = 0;
        prev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b_fp[4]) len++;
            if (b_fp[0] && !prev) begin
                rises++;
                sdat_at_rise = int'(b_fp[2]);
            end
            prev = b_fp[0];
        end
        chk_val("min_frame_len", len, 3);
        chk_val("min_rises", rises, 1);
        chk_val("min_sdat", sdat_at_rise, 1);
        chk_val("min_idle_pins", b_fp & SER, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
